// File: rtl/gfx_pkg.sv
// Shared rasterizer back-end types: pixel-writer state encoding, the oe skid
// margin, and the packed framebuffer write record.
package gfx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } writer_state_e;

   // Pixels that may still arrive after oe falls: fill unit latency plus our stage register.
   localparam int SKID = 3;

   localparam int FB_ADDR_W  = 16;
   localparam int FB_COLOR_W = 16;

   typedef struct packed {
      logic [FB_ADDR_W-1:0]  addr;
      logic [FB_COLOR_W-1:0] color;
   } fb_write_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO with occupancy count; a push into a full FIFO is only
// accepted when a pop happens in the same cycle.
module pixel_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_n_in,
   input  logic                     push_in,
   input  logic [WIDTH-1:0]         push_data_in,
   input  logic                     pop_in,
   output logic [WIDTH-1:0]         head_out,
   output logic                     full_out,
   output logic                     empty_out,
   output logic [$clog2(DEPTH):0]   count_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty_out = (count_q == '0);
   assign full_out  = (count_q == CW'(DEPTH));
   assign count_out = count_q;
   assign do_pop    = pop_in && !empty_out;
   assign do_push   = push_in && (!full_out || do_pop);

   // Gated so the head reads zero while empty rather than stale storage.
   assign head_out  = empty_out ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_in;
   end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel writer: clips fill-unit pixels, converts to linear addresses, queues and
// writes them to the framebuffer. Define PIXEL_WRITER_CLIP_STATS_EN for the clip counter.
module fb_pixel_writer
   import gfx_pkg::*;
#(
   parameter int COORD_WIDTH = 16,
   parameter int FB_WIDTH    = 320,
   parameter int FB_HEIGHT   = 180,
   parameter int COLOR_WIDTH = 16,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                                   clk_in,
   input  logic                                   rst_n_in,
   input  logic                                   tri_start_in,
   input  logic [COLOR_WIDTH-1:0]                 color_in,
   input  logic signed [COORD_WIDTH-1:0]          x_in,
   input  logic signed [COORD_WIDTH-1:0]          y_in,
   input  logic                                   drawing_in,
   input  logic                                   done_in,
   output logic                                   oe_out,
   output logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0]  fb_addr_out,
   output logic [COLOR_WIDTH-1:0]                 fb_data_out,
   output logic                                   fb_we_out,
   input  logic                                   fb_ready_in,
   output logic                                   busy_out,
   output logic                                   done_out,
   output logic                                   overflow_out,
   output logic [15:0]                            clipped_count_out
);

   localparam int AW    = $clog2(FB_WIDTH*FB_HEIGHT);
   localparam int MW    = COORD_WIDTH + $clog2(FB_WIDTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int DW    = AW + COLOR_WIDTH;
   localparam logic [COORD_WIDTH-1:0] X_LIM  = COORD_WIDTH'(FB_WIDTH);
   localparam logic [COORD_WIDTH-1:0] Y_LIM  = COORD_WIDTH'(FB_HEIGHT);
   localparam logic [CNT_W-1:0]       OE_LIM = CNT_W'(FIFO_DEPTH - SKID);

   writer_state_e             state_q, state_d;
   logic [COLOR_WIDTH-1:0]    color_q;
   logic                      overflow_q;
   logic                      stage_valid_q, stage_valid_d;
   logic                      stage_inb_q, stage_inb_d;
   logic [AW-1:0]             stage_addr_q, stage_addr_d;

   logic                      start_tri, accept, in_bounds;
   logic [MW-1:0]             lin_addr;
   logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [DW-1:0]             fifo_head;
   logic [CNT_W-1:0]          fifo_count, occupancy;

   assign start_tri = (state_q == ST_IDLE) && tri_start_in;
   assign accept    = (state_q == ST_ACTIVE) && drawing_in;

   // Wide product so negative or huge coordinates cannot alias into a valid address.
   assign lin_addr  = MW'(y_in) * MW'(FB_WIDTH) + MW'(x_in);
   assign in_bounds = !x_in[COORD_WIDTH-1] && (x_in < X_LIM) &&
                      !y_in[COORD_WIDTH-1] && (y_in < Y_LIM) &&
                      (lin_addr < MW'(FB_WIDTH*FB_HEIGHT));

   always_comb begin
      stage_valid_d = accept;
      stage_inb_d   = accept && in_bounds;
      stage_addr_d  = (accept && in_bounds) ? lin_addr[AW-1:0] : '0;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         stage_valid_q <= 1'b0;
         stage_inb_q   <= 1'b0;
         stage_addr_q  <= '0;
      end else begin
         stage_valid_q <= stage_valid_d;
         stage_inb_q   <= stage_inb_d;
         stage_addr_q  <= stage_addr_d;
      end
   end

   assign fifo_push = stage_valid_q && stage_inb_q;
   assign fifo_pop  = fb_we_out && fb_ready_in;

   pixel_fifo #(
      .WIDTH (DW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .push_in      (fifo_push),
      .push_data_in ({stage_addr_q, color_q}),
      .pop_in       (fifo_pop),
      .head_out     (fifo_head),
      .full_out     (fifo_full),
      .empty_out    (fifo_empty),
      .count_out    (fifo_count)
   );

   assign fb_we_out   = !fifo_empty;
   assign fb_addr_out = fifo_head[COLOR_WIDTH +: AW];
   assign fb_data_out = fifo_head[COLOR_WIDTH-1:0];
   assign occupancy   = fifo_count + CNT_W'(stage_valid_q);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         color_q    <= '0;
         overflow_q <= 1'b0;
      end else if (start_tri) begin
         color_q    <= color_in;
         overflow_q <= 1'b0;
      end else if (fifo_push && fifo_full && !fifo_pop) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow_out = overflow_q;

`ifdef PIXEL_WRITER_CLIP_STATS_EN
   logic [15:0] clip_cnt_q;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         clip_cnt_q <= '0;
      end else if (start_tri) begin
         clip_cnt_q <= '0;
      end else if (stage_valid_q && !stage_inb_q && (clip_cnt_q != 16'hFFFF)) begin
         clip_cnt_q <= clip_cnt_q + 16'd1;
      end
   end

   assign clipped_count_out = clip_cnt_q;
`else
   assign clipped_count_out = '0;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (tri_start_in) state_d = ST_ACTIVE;
         ST_ACTIVE: if (done_in)      state_d = ST_DRAIN;
         // Leave as the last write handshakes so done follows it by one cycle.
         ST_DRAIN:  if (!stage_valid_q &&
                        (fifo_empty || (fifo_count == CNT_W'(1) && fifo_pop)))
                       state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_out = (state_q != ST_IDLE);
      done_out = (state_q == ST_DONE);
      oe_out   = (state_q == ST_ACTIVE) && (occupancy < OE_LIM);
   end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: directed scenarios plus randomized
// pixel streams checked against an arithmetic framebuffer-address model.
module tb_fb_pixel_writer;

   localparam int W = 320;
   localparam int H = 180;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               tri_start;
   logic [15:0]        color;
   logic signed [15:0] x, y;
   logic               drawing, done_in, fb_ready;
   logic               oe, fb_we, busy, done, overflow;
   logic [15:0]        fb_addr, fb_data, clipped;

   fb_pixel_writer dut (
      .clk_in            (clk),
      .rst_n_in          (rst_n),
      .tri_start_in      (tri_start),
      .color_in          (color),
      .x_in              (x),
      .y_in              (y),
      .drawing_in        (drawing),
      .done_in           (done_in),
      .oe_out            (oe),
      .fb_addr_out       (fb_addr),
      .fb_data_out       (fb_data),
      .fb_we_out         (fb_we),
      .fb_ready_in       (fb_ready),
      .busy_out          (busy),
      .done_out          (done),
      .overflow_out      (overflow),
      .clipped_count_out (clipped)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int addr; int data; int cyc; } wr_t;
   wr_t wr_q[$];
   int  exp_q[$];
   int  exp_clip;
   int  done_pulses = 0;
   int  done_cyc = 0;

   always @(negedge clk) begin
      if (rst_n && fb_we && fb_ready) wr_q.push_back('{int'(fb_addr), int'(fb_data), cyc});
      if (rst_n && done) begin
         done_pulses++;
         done_cyc = cyc;
      end
   end

   function automatic bit on_fb(input int px, input int py);
      return (px >= 0) && (px < W) && (py >= 0) && (py < H);
   endfunction

   function automatic int clip_expect(input int n);
`ifdef PIXEL_WRITER_CLIP_STATS_EN
      return (n > 65535) ? 65535 : n;
`else
      return 0 * n;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_tri(input logic [15:0] c);
      tri_start = 1'b1;
      color = c;
      tick();
      tri_start = 1'b0;
      exp_q.delete();
      wr_q.delete();
      exp_clip = 0;
   endtask

   // Drives one pixel in the current cycle and records what the framebuffer should see.
   task automatic drive_pixel(input int px, input int py);
      x = 16'(px);
      y = 16'(py);
      drawing = 1'b1;
      if (on_fb(px, py)) exp_q.push_back(py * W + px);
      else exp_clip++;
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0 = done_pulses;
      for (int i = 0; i < budget && done_pulses == d0; i++) tick();
      checks++;
      if (done_pulses == d0) begin
         errors++;
         $display("FAIL %s: done_out never pulsed within %0d cycles", name, budget);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({oe, fb_we, busy, done, overflow} !== 5'b0 || clipped !== 16'd0 ||
          fb_addr !== 16'd0 || fb_data !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: got oe=%b we=%b busy=%b done=%b ovf=%b clip=%0d addr=%0d data=%h, want all 0",
                  oe, fb_we, busy, done, overflow, clipped, fb_addr, fb_data);
      end
      rst_n = 1'b1;
      tick();
      // Mid-stream reset with pixels queued behind a stalled framebuffer.
      fb_ready = 1'b0;
      start_tri(16'h1234);
      for (int i = 0; i < 4; i++) begin
         drive_pixel(10 + i, 3);
         tick();
      end
      drawing = 1'b0;
      checks++;
      if (fb_we !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_prefill: got we=%b busy=%b, want 1 1", fb_we, busy);
      end
      rst_n = 1'b0;
      #2;
      checks++;
      if ({oe, fb_we, busy, done, overflow} !== 5'b0 || fb_addr !== 16'd0 || fb_data !== 16'd0) begin
         errors++;
         $display("FAIL reset_async: got oe=%b we=%b busy=%b done=%b ovf=%b addr=%0d data=%h, want all 0",
                  oe, fb_we, busy, done, overflow, fb_addr, fb_data);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      fb_ready = 1'b1;
      wr_q.delete();
      begin
         int d0 = done_pulses;
         repeat (6) tick();
         checks++;
         if (busy !== 1'b0 || oe !== 1'b0 || wr_q.size() != 0 || done_pulses != d0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b oe=%b writes=%0d done_pulses=%0d, want 0 0 0 0",
                     busy, oe, wr_q.size(), done_pulses - d0);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_single();
      int t;
      fb_ready = 1'b1;
      start_tri(16'hF800);
      t = cyc;
      drive_pixel(5, 2);
      tick();
      drawing = 1'b0;
      done_in = 1'b1;
      checks++;
      if (fb_we !== 1'b0) begin
         errors++;
         $display("FAIL single_t1: we=%b, want 0", fb_we);
      end
      tick();
      done_in = 1'b0;
      checks++;
      if (fb_we !== 1'b1 || fb_addr !== 16'd645 || fb_data !== 16'hF800 || done !== 1'b0) begin
         errors++;
         $display("FAIL single_t2: we=%b addr=%0d data=%h done=%b, want 1 645 f800 0", fb_we, fb_addr, fb_data, done);
      end
      tick();
      checks++;
      if (done !== 1'b1 || fb_we !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_done: done=%b we=%b busy=%b, want 1 0 1", done, fb_we, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || wr_q.size() != 1 || wr_q[0].cyc != t + 2) begin
         errors++;
         $display("FAIL single_after: done=%b busy=%b writes=%0d write_cyc=%0d, want 0 0 1 %0d",
                  done, busy, wr_q.size(), (wr_q.size() > 0) ? wr_q[0].cyc - t : -1, 2);
      end
      $display("test_single done");
   endtask

   task automatic test_clip();
      int px[4] = '{-1, 320, 0, 319};
      int py[4] = '{0, 0, 180, 179};
      fb_ready = 1'b1;
      start_tri(16'h07E0);
      for (int i = 0; i < 4; i++) begin
         drive_pixel(px[i], py[i]);
         tick();
      end
      drawing = 1'b0;
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      wait_done("clip_done", 50);
      checks++;
      if (wr_q.size() != 1 || wr_q[0].addr != 57599 || wr_q[0].data != 'h07E0) begin
         errors++;
         $display("FAIL clip_write: writes=%0d addr=%0d data=%h, want 1 57599 07e0",
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0].addr : -1, (wr_q.size() > 0) ? wr_q[0].data : -1);
      end
      checks++;
      if (int'(clipped) != clip_expect(3)) begin
         errors++;
         $display("FAIL clip_count: got %0d, want %0d", clipped, clip_expect(3));
      end
      $display("test_clip done");
   endtask

   task automatic test_random(input int seed_round);
      logic [15:0] c = 16'($urandom);
      fb_ready = 1'b1;
      start_tri(c);
      for (int k = 0; k < 150; k++) begin
         if (oe && $urandom_range(0, 3) != 0)
            drive_pixel(int'($urandom_range(0, 360)) - 20, int'($urandom_range(0, 220)) - 20);
         else
            drawing = 1'b0;
         fb_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      drawing = 1'b0;
      fb_ready = 1'b1;
      for (int k = 0; k < 20 && !oe; k++) tick();
      // Final pixel coincides with done_in; it must still be accepted.
      drive_pixel(int'($urandom_range(0, 319)), int'($urandom_range(0, 179)));
      done_in = 1'b1;
      tick();
      drawing = 1'b0;
      done_in = 1'b0;
      wait_done("random_done", 200);
      checks++;
      if (wr_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL random_count round %0d: writes=%0d, want %0d", seed_round, wr_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[i].addr != exp_q[i] || wr_q[i].data != int'(c)) begin
            errors++;
            $display("FAIL random_write[%0d]: addr=%0d data=%h, want %0d %h", i, wr_q[i].addr, wr_q[i].data, exp_q[i], c);
         end
      end
      checks++;
      if (int'(clipped) != clip_expect(exp_clip) || overflow !== 1'b0) begin
         errors++;
         $display("FAIL random_stats: clip=%0d ovf=%b, want %0d 0", clipped, overflow, clip_expect(exp_clip));
      end
      $display("test_random round %0d done: %0d writes, %0d clipped", seed_round, exp_q.size(), exp_clip);
   endtask

   task automatic test_backpressure();
      int sent = 0;
      int max_out = 0;
      int outstanding;
      bit exp_oe;
      fb_ready = 1'b0;
      start_tri(16'hABCD);
      for (int k = 0; k < 100 && sent < 20; k++) begin
         outstanding = sent - wr_q.size();
         if (outstanding > max_out) max_out = outstanding;
         exp_oe = (outstanding < 5);
         checks++;
         if (oe !== exp_oe) begin
            errors++;
            $display("FAIL bp_oe cycle %0d: oe=%b, want %b (outstanding %0d)", k, oe, exp_oe, outstanding);
         end
         if (k == 15) fb_ready = 1'b1;
         if (oe) begin
            drive_pixel(sent * 7, sent);
            sent++;
         end else begin
            drawing = 1'b0;
         end
         tick();
      end
      drawing = 1'b0;
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      wait_done("bp_done", 100);
      checks++;
      if (max_out != 5 || overflow !== 1'b0 || wr_q.size() != 20) begin
         errors++;
         $display("FAIL bp_summary: max_outstanding=%0d ovf=%b writes=%0d, want 5 0 20", max_out, overflow, wr_q.size());
      end
      for (int i = 0; i < 20 && i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[i].addr != exp_q[i] || wr_q[i].data != 'hABCD) begin
            errors++;
            $display("FAIL bp_write[%0d]: addr=%0d data=%h, want %0d abcd", i, wr_q[i].addr, wr_q[i].data, exp_q[i]);
         end
      end
      $display("test_backpressure done");
   endtask

   task automatic test_drain();
      int d0;
      fb_ready = 1'b0;
      start_tri(16'h5A5A);
      for (int i = 0; i < 6; i++) begin
         drive_pixel(100 + i, 50 + i);
         tick();
      end
      drawing = 1'b0;
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      d0 = done_pulses;
      for (int k = 0; k < 60 && done_pulses == d0; k++) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL drain_busy cycle %0d: busy=%b, want 1", k, busy);
         end
         fb_ready = ~fb_ready;
         tick();
      end
      fb_ready = 1'b1;
      tick();
      checks++;
      if (done_pulses != d0 + 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL drain_pulse: pulses=%0d busy=%b, want 1 0", done_pulses - d0, busy);
      end
      checks++;
      if (wr_q.size() != 6 || done_cyc != wr_q[wr_q.size()-1].cyc + 1) begin
         errors++;
         $display("FAIL drain_timing: writes=%0d done_cyc=%0d last_write_cyc=%0d, want 6 and done one cycle after",
                  wr_q.size(), done_cyc, (wr_q.size() > 0) ? wr_q[wr_q.size()-1].cyc : -1);
      end
      for (int i = 0; i < 6 && i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[i].addr != exp_q[i]) begin
            errors++;
            $display("FAIL drain_write[%0d]: addr=%0d, want %0d", i, wr_q[i].addr, exp_q[i]);
         end
      end
      $display("test_drain done");
   endtask

   task automatic test_overflow();
      int stored[$];
      fb_ready = 1'b0;
      start_tri(16'h0F0F);
      for (int i = 0; i < 12; i++) begin
         drive_pixel(i, 100);
         tick();
      end
      drawing = 1'b0;
      for (int i = 0; i < 8; i++) stored.push_back(exp_q[i]);
      tick();
      checks++;
      if (overflow !== 1'b1 || fb_we !== 1'b1) begin
         errors++;
         $display("FAIL ovf_flag: ovf=%b we=%b, want 1 1", overflow, fb_we);
      end
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      fb_ready = 1'b1;
      wait_done("ovf_done", 50);
      tick();
      checks++;
      if (wr_q.size() != 8 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_stored: writes=%0d ovf=%b, want 8 1", wr_q.size(), overflow);
      end
      for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
         checks++;
         if (wr_q[i].addr != stored[i]) begin
            errors++;
            $display("FAIL ovf_write[%0d]: addr=%0d, want %0d", i, wr_q[i].addr, stored[i]);
         end
      end
      start_tri(16'h1111);
      checks++;
      if (overflow !== 1'b0 || int'(clipped) != 0) begin
         errors++;
         $display("FAIL ovf_clear: ovf=%b clip=%0d, want 0 0", overflow, clipped);
      end
      done_in = 1'b1;
      tick();
      done_in = 1'b0;
      wait_done("ovf_clear_done", 20);
      $display("test_overflow done");
   endtask

   initial begin
      tri_start = 1'b0;
      color = '0;
      x = '0;
      y = '0;
      drawing = 1'b0;
      done_in = 1'b0;
      fb_ready = 1'b0;
      exp_clip = 0;
      test_reset();
      test_single();
      test_clip();
      test_backpressure();
      test_drain();
      test_overflow();
      for (int r = 0; r < 3; r++) test_random(r);
      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
